// File: rtl/err_demodulator.sv
// Square-wave modulation driver and synchronous error demodulator for the gyro loop.
// Each period emits (sum_hi - sum_lo) >>> avg_sel, optionally negated, with a one-cycle strobe.
module err_demodulator #(
    parameter int unsigned ADC_W = 14,
    parameter int unsigned ERR_W = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic signed [ADC_W-1:0] i_adc,
    input  logic [CNT_W-1:0]        i_half_cnt,
    input  logic [CNT_W-1:0]        i_wait_cnt,
    input  logic [3:0]              i_avg_sel,
    input  logic                    i_polarity,
    output logic                    o_mod,
    output logic signed [ERR_W-1:0] o_err,
    output logic                    o_err_valid,
    output logic [1:0]              o_cstate
);
    localparam int unsigned ACC_W = ADC_W + 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAcc  = 2'd2,
        StHold = 2'd3
    } state_e;

    state_e                  r_state;
    logic                    r_mod;
    logic [CNT_W-1:0]        r_ph;
    logic [CNT_W-1:0]        r_half;
    logic [CNT_W-1:0]        r_wait;
    logic [3:0]              r_avg;
    logic                    r_pol;
    logic [15:0]             r_cnt;
    logic signed [ACC_W-1:0] r_acc_hi;
    logic signed [ACC_W-1:0] r_acc_lo;
    logic signed [ERR_W-1:0] r_err;
    logic                    r_err_valid;

    logic [CNT_W-1:0]        w_half_in;
    logic signed [ACC_W-1:0] w_adc_ext;
    logic                    w_smp;
    logic signed [ACC_W-1:0] w_acc_hi_nx;
    logic signed [ACC_W-1:0] w_acc_lo_nx;
    logic signed [ACC_W-1:0] w_diff;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [ERR_W-1:0] w_err_raw;
    logic signed [ERR_W-1:0] w_err_nx;
    logic                    w_half_end;
    logic                    w_wait_end;
    logic [15:0]             w_n_last;

    assign w_half_in   = (i_half_cnt < CNT_W'(4)) ? CNT_W'(4) : i_half_cnt;
    assign w_adc_ext   = ACC_W'(i_adc);
    assign w_smp       = (r_state == StAcc);
    // The half-end sample still belongs to the ending half, so fold it in combinationally.
    assign w_acc_hi_nx = r_acc_hi + ((w_smp && r_mod) ? w_adc_ext : '0);
    assign w_acc_lo_nx = r_acc_lo + ((w_smp && !r_mod) ? w_adc_ext : '0);
    assign w_diff      = w_acc_hi_nx - w_acc_lo_nx;
    assign w_shift     = w_diff >>> r_avg;
    assign w_err_raw   = ERR_W'(w_shift);
    assign w_err_nx    = r_pol ? -w_err_raw : w_err_raw;
    assign w_half_end  = (r_ph == r_half - CNT_W'(1));
    assign w_wait_end  = (r_ph == r_wait - CNT_W'(1));
    assign w_n_last    = (16'd1 << r_avg) - 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_mod       <= 1'b0;
            r_ph        <= '0;
            r_half      <= '0;
            r_wait      <= '0;
            r_avg       <= '0;
            r_pol       <= 1'b0;
            r_cnt       <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_err       <= '0;
            r_err_valid <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;
            if (r_state == StIdle) begin
                r_mod    <= 1'b0;
                r_ph     <= '0;
                r_cnt    <= '0;
                r_acc_hi <= '0;
                r_acc_lo <= '0;
                r_half   <= w_half_in;
                r_wait   <= i_wait_cnt;
                r_avg    <= i_avg_sel;
                r_pol    <= i_polarity;
                if (i_en) begin
                    r_mod   <= 1'b1;
                    r_state <= (i_wait_cnt == '0) ? StAcc : StWait;
                end
            end else if (!i_en) begin
                // Partial period is discarded; o_err keeps its last value.
                r_state  <= StIdle;
                r_mod    <= 1'b0;
                r_ph     <= '0;
                r_cnt    <= '0;
                r_acc_hi <= '0;
                r_acc_lo <= '0;
            end else if (w_half_end) begin
                r_mod <= ~r_mod;
                r_ph  <= '0;
                r_cnt <= '0;
                if (r_mod) begin
                    r_acc_hi <= w_acc_hi_nx;
                    r_state  <= (r_wait == '0) ? StAcc : StWait;
                end else begin
                    r_err       <= w_err_nx;
                    r_err_valid <= 1'b1;
                    r_acc_hi    <= '0;
                    r_acc_lo    <= '0;
                    r_half      <= w_half_in;
                    r_wait      <= i_wait_cnt;
                    r_avg       <= i_avg_sel;
                    r_pol       <= i_polarity;
                    r_state     <= (i_wait_cnt == '0) ? StAcc : StWait;
                end
            end else begin
                r_ph <= r_ph + CNT_W'(1);
                unique case (r_state)
                    StWait: begin
                        if (w_wait_end) r_state <= StAcc;
                    end
                    StAcc: begin
                        r_acc_hi <= w_acc_hi_nx;
                        r_acc_lo <= w_acc_lo_nx;
                        r_cnt    <= r_cnt + 16'd1;
                        if (r_cnt == w_n_last) r_state <= StHold;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_mod       = r_mod;
    assign o_err       = r_err;
    assign o_err_valid = r_err_valid;
    assign o_cstate    = r_state;

endmodule

// File: tb/tb_err_demodulator.sv
// Bench for err_demodulator: per-cycle comparison against a period-level behavioural model,
// directed scenarios with literal expectations, then randomized config/enable/sample stimulus.
module tb_err_demodulator;
    localparam int ADC_W = 14;
    localparam int ERR_W = 32;
    localparam int CNT_W = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic signed [ADC_W-1:0] adc;
    logic [CNT_W-1:0]        half_cnt;
    logic [CNT_W-1:0]        wait_cnt;
    logic [3:0]              avg_sel;
    logic                    polarity;
    logic                    mod;
    logic signed [ERR_W-1:0] err;
    logic                    err_valid;
    logic [1:0]              cstate;

    err_demodulator #(.ADC_W(ADC_W), .ERR_W(ERR_W), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_adc       (adc),
        .i_half_cnt  (half_cnt),
        .i_wait_cnt  (wait_cnt),
        .i_avg_sel   (avg_sel),
        .i_polarity  (polarity),
        .o_mod       (mod),
        .o_err       (err),
        .o_err_valid (err_valid),
        .o_cstate    (cstate)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: position m_t within the current period, config latched at period start.
    bit                      m_run;
    int                      m_t, m_h, m_w, m_a;
    bit                      m_p;
    longint                  m_hi, m_lo;
    logic signed [ERR_W-1:0] m_err;
    bit                      m_valid;

    int     vidx[$];
    longint last_err;
    int     hi_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_t = 0; m_hi = 0; m_lo = 0; m_err = '0; m_valid = 0;
    endfunction

    function automatic void model_latch();
        m_h = (half_cnt < 4) ? 4 : int'(half_cnt);
        m_w = int'(wait_cnt);
        m_a = int'(avg_sel);
        m_p = polarity;
    endfunction

    function automatic bit m_mod();
        return m_run && (m_t < m_h);
    endfunction

    function automatic int m_state();
        int p;
        if (!m_run) return 0;
        p = (m_t < m_h) ? m_t : m_t - m_h;
        if (p < m_w) return 1;
        if (p < m_w + (1 << m_a)) return 2;
        return 3;
    endfunction

    function automatic void model_edge(input bit en_v, input longint adc_v);
        int     p;
        bit     hi;
        longint s;
        m_valid = 0;
        if (!m_run) begin
            if (en_v) begin
                m_run = 1; m_t = 0; m_hi = 0; m_lo = 0;
                model_latch();
            end
        end else if (!en_v) begin
            m_run = 0;
        end else begin
            hi = (m_t < m_h);
            p  = hi ? m_t : m_t - m_h;
            if (p >= m_w && p < m_w + (1 << m_a)) begin
                if (hi) m_hi += adc_v;
                else    m_lo += adc_v;
            end
            m_t++;
            if (m_t == 2 * m_h) begin
                s = (m_hi - m_lo) >>> m_a;
                if (m_p) s = -s;
                m_err   = s[ERR_W-1:0];
                m_valid = 1;
                model_latch();
                m_t = 0; m_hi = 0; m_lo = 0;
            end
        end
    endfunction

    task automatic step(input bit en_v, input int adc_v);
        @(negedge clk);
        en  = en_v;
        adc = ADC_W'(adc_v);
        model_edge(en_v, longint'(adc));
        @(posedge clk);
        #1;
        check("mod",    longint'(mod),       longint'(m_mod()));
        check("err",    longint'(err),       longint'(m_err));
        check("valid",  longint'(err_valid), longint'(m_valid));
        check("cstate", longint'(cstate),    longint'(m_state()));
    endtask

    // Enable from IDLE and run ncyc cycles from cycle 0; records strobe positions.
    task automatic run_dir(input int h, input int w, input int a, input bit p, input int hv,
                           input int lv, input int ncyc, input int chg_at, input int chg_h);
        int h_eff;
        half_cnt = CNT_W'(h);
        wait_cnt = CNT_W'(w);
        avg_sel  = 4'(a);
        polarity = p;
        h_eff    = (h < 4) ? 4 : h;
        vidx.delete();
        hi_cnt = 0;
        step(1'b0, 0);
        step(1'b1, 0);
        for (int c = 0; c < ncyc; c++) begin
            if (err_valid) begin
                vidx.push_back(c);
                last_err = longint'(err);
            end
            if (c < 2 * h_eff && mod) hi_cnt++;
            if (c == chg_at) half_cnt = CNT_W'(chg_h);
            step(1'b1, m_mod() ? hv : lv);
        end
        step(1'b0, 0);
    endtask

    initial begin
        int nv;
        rst_n = 1'b0; en = 1'b0; adc = '0;
        half_cnt = 8; wait_cnt = 2; avg_sel = 2; polarity = 1'b0;
        model_reset();
        #1;
        check("rst_mod",    longint'(mod),       0);
        check("rst_err",    longint'(err),       0);
        check("rst_valid",  longint'(err_valid), 0);
        check("rst_cstate", longint'(cstate),    0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_dir(8, 2, 2, 0, 100, -100, 49, -1, 0);
        check("s1_nvalid", vidx.size(), 3);
        if (vidx.size() == 3) begin
            check("s1_v0", vidx[0], 16);
            check("s1_v1", vidx[1], 32);
            check("s1_v2", vidx[2], 48);
        end
        check("s1_err",  last_err, 200);
        check("s1_high", hi_cnt,   8);

        run_dir(8, 2, 2, 1, 100, -100, 17, -1, 0);
        check("pol_err", last_err, -200);

        run_dir(8, 2, 2, 0, 500, 500, 17, -1, 0);
        check("const_err", last_err, 0);

        run_dir(8, 6, 3, 0, 80, -80, 17, -1, 0);
        check("trunc_err", last_err, 40);

        run_dir(2, 1, 1, 0, 10, -10, 9, -1, 0);
        check("clamp_high", hi_cnt, 4);
        check("clamp_nvalid", vidx.size(), 1);
        if (vidx.size() == 1) check("clamp_v0", vidx[0], 8);

        run_dir(8, 2, 2, 0, 100, -100, 41, 5, 12);
        check("hchg_nvalid", vidx.size(), 2);
        if (vidx.size() == 2) begin
            check("hchg_v0", vidx[0], 16);
            check("hchg_v1", vidx[1], 40);
        end

        // Drop enable at cycle 10: no strobe, o_err keeps the previous period's value.
        half_cnt = 8; wait_cnt = 2; avg_sel = 2; polarity = 1'b0;
        step(1'b0, 0);
        step(1'b1, 0);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, m_mod() ? 100 : -100);
            if (err_valid) nv++;
        end
        step(1'b0, 0);
        check("dis_mod", longint'(mod), 0);
        check("dis_err", longint'(err), 200);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 0);
            if (err_valid) nv++;
        end
        check("dis_nvalid", nv, 0);
        run_dir(8, 2, 2, 0, 100, -100, 17, -1, 0);
        check("reen_nvalid", vidx.size(), 1);
        if (vidx.size() == 1) check("reen_v0", vidx[0], 16);

        // Asynchronous reset in the middle of accumulation.
        step(1'b0, 0);
        step(1'b1, 0);
        repeat (3) step(1'b1, 100);
        check("pre_rst_cstate", longint'(cstate), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mod",    longint'(mod),       0);
        check("arst_err",    longint'(err),       0);
        check("arst_valid",  longint'(err_valid), 0);
        check("arst_cstate", longint'(cstate),    0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_dir(8, 2, 2, 0, 100, -100, 17, -1, 0);
        check("post_rst_err", last_err, 200);

        // Randomized: config may change any time, enable drops occasionally.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                half_cnt = CNT_W'($urandom_range(0, 12));
                wait_cnt = CNT_W'($urandom_range(0, 14));
                avg_sel  = 4'($urandom_range(0, 4));
                polarity = 1'($urandom_range(0, 1));
            end
            step($urandom_range(0, 99) >= 2, int'($signed(ADC_W'($urandom))));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/err_demodulator.md
Name: err_demodulator

Overview:
- Square-wave phase-modulation driver and synchronous error demodulator for the closed gyro loop.
- Generates the modulation square wave and gates ADC samples in each half-period after a settle window.
- Subtracts low-half from high-half sums, averages, and emits one signed error word per modulation period.
- o_err feeds the integrator's i_err input; o_err_valid strobes each new value.

Parameters:
ADC_W, 14, signed ADC sample width
ERR_W, 32, signed error output width (must be >= ADC_W+16)
CNT_W, 32, width of period/wait counters

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  run enable; low forces IDLE
i_adc  in  ADC_W  signed detector sample, sampled every clock
i_half_cnt  in  CNT_W  modulation half-period in clocks (values <4 treated as 4)
i_wait_cnt  in  CNT_W  settle clocks skipped at start of each half
i_avg_sel  in  4  samples per half = 2^i_avg_sel (values >15 impossible; 4-bit)
i_polarity  in  1  1 = negate output error
o_mod  out  1  modulation square wave
o_err  out  ERR_W  signed demodulated error
o_err_valid  out  1  one-cycle strobe, new o_err
o_cstate  out  2  current state, for simulation

Behaviour:
- Reset (async): o_mod=0, o_err=0, o_err_valid=0, all counters/accumulators=0, state=IDLE.
- States: IDLE(0), WAIT(1), ACC(2), HOLD(3). Phase counter ph counts clocks within a half.
- Config latch: i_half_cnt (clamped), i_wait_cnt, i_avg_sel, i_polarity sampled into shadow registers in IDLE and at every high-half start; constant for the whole period.
- IDLE: o_mod=0, ph=0. When i_en=1, latch config, o_mod<=1, ph<=0, next = WAIT (or ACC if wait=0).
- Cycle numbering: cycle 0 = first cycle o_mod=1. High half = cycles 0..H-1; low half = cycles H..2H-1 (H = latched half_cnt).
- WAIT: while ph < wait, no sampling. ph==wait-1 -> ACC.
- ACC: add sign-extended i_adc into acc_hi (o_mod=1) or acc_lo (o_mod=0). Take N=2^avg_sel samples, then -> HOLD.
- HOLD: idle until half end.
- Half end (ph==H-1, any state):
  - toggle o_mod; ph<=0; next = WAIT/ACC per wait.
  - if wait+N > H, accumulation is truncated at the half end; divisor is still 2^avg_sel.
  - if wait >= H, no samples are taken.
- Sampling on the half-end cycle itself counts toward the ending half.
- Period end (low half end, ph==H-1 with o_mod=0):
  - next cycle: o_err = sext((acc_hi - acc_lo) >>> avg_sel), negated if polarity; o_err_valid=1 for exactly that cycle.
  - accumulators cleared same cycle; config re-latched; o_mod=1.
- Accumulators ADC_W+16 bits signed; subtraction done at that width; arithmetic shift; no saturation needed.
- Latency: first o_err_valid at cycle 2H after o_mod rises. Period of valids = 2H clocks.
- i_en falls mid-period: next cycle state=IDLE, o_mod=0, accumulators cleared, partial period discarded, no valid, o_err holds last value.
- i_en re-asserted: fresh period starts, cycle 0 definition reapplies.
- Config inputs changing mid-period have no effect until the next high-half start.
- o_err holds between strobes; never changes except with o_err_valid=1 or reset.

Test Plan:
- Reset then i_en=1, H=8, wait=2, avg_sel=2, i_adc=+100 while o_mod=1 / -100 while o_mod=0, polarity=0 -> o_mod 8 high/8 low; o_err=200, valid at cycle 16, 32, 48 only.
- Same but polarity=1 -> o_err=-200; i_adc constant 500 both halves -> o_err=0.
- H=8, wait=6, avg_sel=3 (truncated: 2 samples/half), +80/-80 -> o_err=(160+160)>>>3=40.
- i_half_cnt=2 -> behaves as H=4 (o_mod 4/4); i_half_cnt changed 8->12 at cycle 5 -> current period still 16 clocks, next period 24.
- i_en deasserted at cycle 10 -> o_mod=0 next cycle, no valid at 16, o_err keeps prior value; re-enable -> valid 16 cycles after new o_mod rise.
- i_rst_n asserted mid-ACC -> all outputs 0 immediately (async), state IDLE; recovers cleanly after release.
